// File: rtl/disp_source_sched.sv
// disp_source_sched: picks one of eight 32-bit debug sources (manual button or auto-rotate),
// latches it with optional freeze, and scans it onto a 4-digit seven-segment display.
module disp_source_sched #(
    parameter int SCAN_DIV        = 17,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ROTATE_CYCLES   = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         auto_en,
    input  logic         btn_next,
    input  logic         freeze,
    input  logic         high_degree,
    input  logic [255:0] src_flat,
    output logic [2:0]   sel,
    output logic [31:0]  disp_value,
    output logic [3:0]   AN,
    output logic [7:0]   SEGMENT
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(ROTATE_CYCLES);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_CYCLES - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t state, state_next;
    logic s1, s2, stable, stable_q, step, expire;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rot_cnt, rot_next;
    logic [2:0] sel_next;
    logic [SCAN_DIV+1:0] scan_cnt;
    logic [1:0] k;
    logic [3:0] nib;
    logic [6:0] hex;

    // Button: synchronize, debounce, then a registered pulse on each accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            step     <= 1'b0;
            db_cnt   <= '0;
        end else begin
            s1       <= btn_next;
            s2       <= s1;
            stable_q <= stable;
            step     <= stable & ~stable_q;
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MANUAL;
            sel     <= 3'd0;
            rot_cnt <= '0;
        end else begin
            state   <= state_next;
            sel     <= sel_next;
            rot_cnt <= rot_next;
        end
    end

    always_comb state_next = auto_en ? AUTO : MANUAL;

    // Step and expiry share one increment; rot_cnt idles at 0 in manual so entering auto starts fresh.
    always_comb begin
        expire   = (state == AUTO) && (rot_cnt == ROT_LAST);
        sel_next = (step || expire) ? sel + 3'd1 : sel;
        rot_next = (state == MANUAL || step || expire) ? '0 : rot_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp_value <= 32'd0;
        else if (!freeze)
            disp_value <= src_flat[{sel, 5'd0} +: 32];
    end

    assign k   = scan_cnt[SCAN_DIV+1:SCAN_DIV];
    assign nib = disp_value[{high_degree, k, 2'b00} +: 4];

    always_comb begin
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            default: hex = 7'h0E;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            AN       <= 4'b1111;
            SEGMENT  <= 8'hFF;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            AN       <= ~(4'b0001 << k);
            SEGMENT  <= {1'b1, hex};
        end
    end
endmodule
